// File: rtl/mod10_counter.sv
// Modulo-10 BCD down-counter digit with clear, parallel load and
// borrow-out for cascading several digits.
module mod10_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       clearn,
    input  logic       loadn,
    input  logic       enable,
    input  logic [3:0] input_number,
    output logic [3:0] output_number,
    output logic       tc,
    output logic       zero
);

    logic [3:0] count_q;
    logic [3:0] count_d;
    logic [3:0] load_val;
    logic [3:0] dec_val;
    logic       is_zero;

    // Non-BCD load values saturate at 9 so the count never leaves 0..9.
    assign load_val = (input_number > 4'd9) ? 4'd9 : input_number;

    assign is_zero = (count_q == 4'd0);
    assign dec_val = is_zero ? 4'd9 : (count_q - 4'd1);

    always_comb begin
        count_d = count_q;
        if (!clearn) begin
            count_d = 4'd0;
        end else if (!loadn) begin
            count_d = load_val;
        end else if (enable) begin
            count_d = dec_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign output_number = count_q;
    assign zero          = is_zero;
    // Borrow only when the next edge will actually wrap 0 -> 9.
    assign tc = is_zero & enable & ~reset & clearn & loadn;

endmodule

// File: tb/tb_mod10_counter.sv
// Self-checking bench for mod10_counter: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_mod10_counter;

    logic       clock;
    logic       reset;
    logic       clearn;
    logic       loadn;
    logic       enable;
    logic [3:0] input_number;
    logic [3:0] output_number;
    logic       tc;
    logic       zero;

    int n_checks;
    int n_fail;
    int m;

    mod10_counter dut (
        .clock         (clock),
        .reset         (reset),
        .clearn        (clearn),
        .loadn         (loadn),
        .enable        (enable),
        .input_number  (input_number),
        .output_number (output_number),
        .tc            (tc),
        .zero          (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic drive(input logic r, input logic c, input logic l,
                         input logic e, input logic [3:0] n);
        reset        = r;
        clearn       = c;
        loadn        = l;
        enable       = e;
        input_number = n;
        #1;
    endtask

    // Advance one edge; the model follows the priority rules on the
    // inputs present at that edge.
    task automatic tick();
        @(posedge clock);
        if (reset)
            m = 0;
        else if (!clearn)
            m = 0;
        else if (!loadn)
            m = (int'(input_number) > 9) ? 9 : int'(input_number);
        else if (enable)
            m = (m + 9) % 10;
        @(negedge clock);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 4'd0);
        tick();
        tick();
        n_checks++;
        if (output_number !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_count got %0d want 0", output_number);
        end
        n_checks++;
        if (zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_zero got %b want 1", zero);
        end
        n_checks++;
        if (tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tc got %b want 0", tc);
        end
    endtask

    task automatic test_load_count();
        int exp_seq[8] = '{5, 4, 3, 2, 1, 0, 9, 8};
        drive(1, 1, 1, 0, 4'd0);
        tick();
        drive(0, 1, 0, 0, 4'd5);
        tick();
        drive(0, 1, 1, 1, 4'd0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (output_number !== 4'(exp_seq[i]) ||
                zero !== (exp_seq[i] == 0) ||
                tc !== (exp_seq[i] == 0)) begin
                n_fail++;
                $display("FAIL load_count[%0d] got n=%0d z=%b tc=%b want n=%0d",
                         i, output_number, zero, tc, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_clear();
        drive(0, 1, 0, 0, 4'd3);
        tick();
        drive(0, 0, 1, 1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (output_number !== 4'd0 || tc !== 1'b0 || zero !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_hold[%0d] got n=%0d tc=%b z=%b want n=0 tc=0 z=1",
                         i, output_number, tc, zero);
            end
        end
        drive(0, 1, 1, 1, 4'd0);
        n_checks++;
        if (tc !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_release_tc got %b want 1", tc);
        end
        tick();
        n_checks++;
        if (output_number !== 4'd9) begin
            n_fail++;
            $display("FAIL clear_after_9 got %0d want 9", output_number);
        end
        tick();
        n_checks++;
        if (output_number !== 4'd8) begin
            n_fail++;
            $display("FAIL clear_after_8 got %0d want 8", output_number);
        end
    endtask

    task automatic test_hold();
        drive(0, 1, 0, 0, 4'd7);
        tick();
        drive(0, 1, 1, 0, 4'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (output_number !== 4'd7 || tc !== 1'b0 || zero !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d] got n=%0d tc=%b z=%b want n=7 tc=0 z=0",
                         i, output_number, tc, zero);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int v = 10; v < 16; v++) begin
            drive(0, 1, 0, 1, 4'(v));
            tick();
            tick();
            n_checks++;
            if (output_number !== 4'd9 || tc !== 1'b0) begin
                n_fail++;
                $display("FAIL load_oor[%0d] got n=%0d tc=%b want n=9 tc=0",
                         v, output_number, tc);
            end
        end
    endtask

    task automatic test_reset_override();
        drive(0, 1, 0, 0, 4'd4);
        tick();
        drive(1, 1, 0, 1, 4'd8);
        tick();
        n_checks++;
        if (output_number !== 4'd0 || zero !== 1'b1 || tc !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_override got n=%0d z=%b tc=%b want n=0 z=1 tc=0",
                     output_number, zero, tc);
        end
        drive(0, 1, 1, 1, 4'd0);
        tick();
        n_checks++;
        if (output_number !== 4'd9) begin
            n_fail++;
            $display("FAIL reset_resume got %0d want 9", output_number);
        end
    endtask

    task automatic test_wrap();
        drive(0, 1, 0, 0, 4'd1);
        tick();
        drive(0, 1, 1, 1, 4'd0);
        n_checks++;
        if (tc !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pre got tc=%b z=%b want tc=0 z=0", tc, zero);
        end
        tick();
        n_checks++;
        if (output_number !== 4'd0 || tc !== 1'b1 || zero !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_at0 got n=%0d tc=%b z=%b want n=0 tc=1 z=1",
                     output_number, tc, zero);
        end
        tick();
        n_checks++;
        if (output_number !== 4'd9 || tc !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_after got n=%0d tc=%b z=%b want n=9 tc=0 z=0",
                     output_number, tc, zero);
        end
    endtask

    task automatic test_random();
        logic exp_tc;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)));
            exp_tc = (m == 0) && enable && !reset && clearn && loadn;
            n_checks++;
            if (output_number !== 4'(m) || zero !== (m == 0) || tc !== exp_tc) begin
                n_fail++;
                $display("FAIL random[%0d] got n=%0d z=%b tc=%b want n=%0d z=%b tc=%b",
                         i, output_number, zero, tc, m, (m == 0), exp_tc);
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m        = 0;
        drive(1, 1, 1, 0, 4'd0);
        @(negedge clock);
        test_reset();
        test_load_count();
        test_clear();
        test_hold();
        test_out_of_range();
        test_reset_override();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod10_counter.md
MOD10_COUNTER -- requirements
Module: mod10_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port clearn, input, 1 bit: synchronous, active-low clear of the count.
REQ-005 Port loadn, input, 1 bit: synchronous, active-low parallel load.
REQ-006 Port enable, input, 1 bit: active-high count enable.
REQ-007 Port input_number, input, 4 bits: BCD value to load.
REQ-008 Port output_number, output, 4 bits: current count, registered, always in the range 0..9.
REQ-009 Port tc, output, 1 bit: terminal count (borrow out), combinational, for cascading digits.
REQ-010 Port zero, output, 1 bit: count-equals-zero flag, combinational.

Function
REQ-011 The counter SHALL be a modulo-10 down-counter.
REQ-012 Priority at each rising edge SHALL be, highest first: reset, clearn=0, loadn=0, enable=1, hold.
REQ-013 With reset=1, count SHALL become 0.
REQ-014 With reset=0 and clearn=0, count SHALL become 0, regardless of loadn and enable.
REQ-015 With reset=0, clearn=1 and loadn=0, count SHALL become input_number, regardless of enable.
REQ-016 During a load, input_number values 10..15 SHALL be loaded as 9.
REQ-017 With reset=0, clearn=1, loadn=1 and enable=1, count SHALL decrement by 1 each edge.
REQ-018 Decrementing from 0 SHALL wrap the count to 9.
REQ-019 With reset=0, clearn=1, loadn=1 and enable=0, count SHALL hold.
REQ-020 zero SHALL be 1 if and only if count==0, independent of the control inputs.
REQ-021 tc SHALL be 1 if and only if count==0, enable=1, reset=0, clearn=1 and loadn=1.
REQ-022 tc therefore SHALL be high exactly in the cycle whose next edge wraps the count 0->9.
REQ-023 Latency: a load, clear or decrement SHALL appear on output_number one edge after the controlling inputs are sampled; tc and zero SHALL follow output_number in the same cycle.
REQ-024 Inputs are synchronous to clock; the block SHALL contain no asynchronous paths to state.

Reset
REQ-025 After any edge with reset=1, the outputs SHALL be: output_number=0, zero=1, tc=0.
REQ-026 Assertion of reset mid-count SHALL override a load or decrement in the same cycle.
REQ-027 Counting SHALL resume from 0 on the first enabled edge after reset deasserts, producing the sequence 0->9.
REQ-028 The power-up state before the first reset is undefined; a bench SHALL apply reset first.

Verification
REQ-029 Load and count: reset, enable=0, input_number=5, loadn=0 for one edge, then loadn=1 and enable=1.
  -> output_number SHALL be 5,4,3,2,1,0,9,8 on successive edges.
  -> zero=1 only while the count is 0.
  -> tc=1 only in the cycle where the count is 0 and enable=1.
REQ-030 Clear priority: count at 3, clearn=0 with enable=1.
  -> output_number SHALL be 0 and SHALL hold at 0 while clearn=0.
  -> tc SHALL be 0 throughout.
  -> After clearn=1, the next values SHALL be 9,8,...
REQ-031 Hold: count at 7, enable=0 for 5 edges.
  -> output_number SHALL stay 7; tc=0; zero=0.
REQ-032 Out-of-range load: input_number=12, loadn=0.
  -> output_number SHALL be 9.
  -> With loadn=0 and enable=1 held, output_number SHALL stay 9 (load overrides count).
REQ-033 Reset override: count at 4, reset=1 together with loadn=0 and input_number=8.
  -> output_number SHALL be 0, zero=1, tc=0.
REQ-034 Wrap with cascade: count at 0 with enable=1.
  -> tc SHALL be 1 for exactly that one cycle.
  -> output_number SHALL be 9 after the next edge, with tc=0 and zero=0.
